id_stage: RTL and testbench

- Parametrised, pipelined instruction-decode stage for the RV32/RV64 integer pipeline. Sits between IF and EX.
- Holds one instruction in a valid/allowin pipeline register and owns the architectural register file (WB write port).
- Tracks in-flight register writes with a per-register scoreboard, stalls on RAW hazards, and resolves branches and jumps at hand-off to EX.

---
 rtl/id_stage.sv | 240 ++++++++++++++++++++++++
 tb/tb_id_stage.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32/RV64 decode stage with register file, write scoreboard and branch resolve.
// Optional ID_WB_BYPASS_EN: a source waiting on its last in-flight write takes WB data directly.
module id_stage #(
    parameter int XLEN = 32,
    parameter int SB_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs_to_ds_valid,
    input  logic [XLEN+31:0]  fs_data,
    output logic              ds_allowin,
    output logic              ds_to_es_valid,
    input  logic              es_allowin,
    output logic [4*XLEN+5:0] ds_data,
    input  logic              wb_we,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wdata,
    output logic              br_taken,
    output logic [XLEN-1:0]   br_target
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [SB_W-1:0] SB_MAX = '1;
    localparam logic [SB_W-1:0] SB_ONE = SB_W'(1);

    logic            ds_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rf [32];
    logic [SB_W-1:0] sb_cnt [32];

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];

    logic is_lui, is_auipc, is_jal, is_jalr;
    logic is_branch, is_load, is_store, is_opimm, is_op;

    assign is_lui    = opcode == OP_LUI;
    assign is_auipc  = opcode == OP_AUIPC;
    assign is_jal    = opcode == OP_JAL;
    assign is_jalr   = opcode == OP_JALR;
    assign is_branch = opcode == OP_BRANCH;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_opimm  = opcode == OP_OPIMM;
    assign is_op     = opcode == OP_OP;

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};

    logic [XLEN-1:0] imm;
    logic            use_rs1;
    logic            use_rs2;
    logic            we_op;
    logic            rf_we;

    always_comb begin
        imm     = '0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        we_op   = 1'b0;
        unique case (1'b1)
            is_lui, is_auipc: begin
                imm   = imm_u;
                we_op = 1'b1;
            end
            is_jal: begin
                imm   = imm_j;
                we_op = 1'b1;
            end
            is_jalr, is_load, is_opimm: begin
                imm     = imm_i;
                use_rs1 = 1'b1;
                we_op   = 1'b1;
            end
            is_branch: begin
                imm     = imm_b;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            is_store: begin
                imm     = imm_s;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            is_op: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                we_op   = 1'b1;
            end
            default: ;
        endcase
    end

    assign rf_we = we_op & (rd != 5'd0);

    logic [XLEN-1:0] rf_rs1;
    logic [XLEN-1:0] rf_rs2;
    logic            byp1;
    logic            byp2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    assign rf_rs1 = (rs1 == 5'd0) ? '0 : rf[rs1];
    assign rf_rs2 = (rs2 == 5'd0) ? '0 : rf[rs2];

    // x0 never has a pending count, so a hit always names a real register
`ifdef ID_WB_BYPASS_EN
    assign byp1 = wb_we & (wb_rd == rs1) & (sb_cnt[rs1] == SB_ONE);
    assign byp2 = wb_we & (wb_rd == rs2) & (sb_cnt[rs2] == SB_ONE);
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif

    assign rs1_val = byp1 ? wb_wdata : rf_rs1;
    assign rs2_val = byp2 ? wb_wdata : rf_rs2;

    logic hz1;
    logic hz2;
    logic hz_rd;
    logic stall;
    logic ready_go;
    logic fire;

    assign hz1      = use_rs1 & (sb_cnt[rs1] != '0) & ~byp1;
    assign hz2      = use_rs2 & (sb_cnt[rs2] != '0) & ~byp2;
    assign hz_rd    = rf_we & (sb_cnt[rd] == SB_MAX);
    assign stall    = ds_valid & (hz1 | hz2 | hz_rd);
    assign ready_go = ~stall;

    assign ds_allowin     = rst | ~ds_valid | (ready_go & es_allowin);
    assign ds_to_es_valid = ~rst & ds_valid & ready_go;
    assign fire           = ds_to_es_valid & es_allowin;

    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = rs1_val == rs2_val;
            3'b001:  br_cond = rs1_val != rs2_val;
            3'b100:  br_cond = $signed(rs1_val) <  $signed(rs2_val);
            3'b101:  br_cond = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  br_cond = rs1_val <  rs2_val;
            3'b111:  br_cond = rs1_val >= rs2_val;
            default: br_cond = 1'b0;
        endcase
    end

    logic            jump;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign jump     = is_jal | is_jalr | (is_branch & br_cond);
    assign jalr_sum = rs1_val + imm;
    assign target   = is_jalr ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
                              : pc + imm;

    assign br_taken  = fire & jump;
    assign br_target = br_taken ? target : '0;

    assign ds_data = {imm, rs2_val, rs1_val, pc, rd, rf_we};

    // IF's offer in a redirect cycle is on the wrong path
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_valid <= 1'b0;
        end else if (ds_allowin) begin
            ds_valid <= fs_to_ds_valid & ~br_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (fs_to_ds_valid & ds_allowin) begin
            {instr, pc} <= fs_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_we && (wb_rd != 5'd0)) begin
            rf[wb_rd] <= wb_wdata;
        end
    end

    logic [31:0] sb_inc;
    logic [31:0] sb_dec;

    always_comb begin
        sb_inc        = '0;
        sb_dec        = '0;
        sb_inc[rd]    = fire & rf_we;
        sb_dec[wb_rd] = wb_we & (wb_rd != 5'd0) & (sb_cnt[wb_rd] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                sb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (sb_inc[i] & ~sb_dec[i]) begin
                    sb_cnt[i] <= sb_cnt[i] + 1'b1;
                end else if (sb_dec[i] & ~sb_inc[i]) begin
                    sb_cnt[i] <= sb_cnt[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and random instruction streams for id_stage,
// scored against an issue/retire model of registers and pending writes.
module tb_id_stage;
    localparam int XLEN   = 32;
    localparam int SB_W   = 2;
    localparam int SB_MAX = (1 << SB_W) - 1;
`ifdef ID_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              fs_to_ds_valid;
    logic [XLEN+31:0]  fs_data;
    logic              ds_allowin;
    logic              ds_to_es_valid;
    logic              es_allowin;
    logic [4*XLEN+5:0] ds_data;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_wdata;
    logic              br_taken;
    logic [XLEN-1:0]   br_target;

    always #5 clk = ~clk;

    id_stage #(.XLEN(XLEN), .SB_W(SB_W)) dut (
        .clk(clk), .rst(rst),
        .fs_to_ds_valid(fs_to_ds_valid), .fs_data(fs_data),
        .ds_allowin(ds_allowin), .ds_to_es_valid(ds_to_es_valid),
        .es_allowin(es_allowin), .ds_data(ds_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
        .br_taken(br_taken), .br_target(br_target)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef enum {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR,
                  K_LD, K_ST, K_OPI, K_OP, K_BAD} kind_e;

    typedef struct {
        kind_e           kind;
        logic [XLEN-1:0] imm;
        bit              imm_ok;
        bit              use1;
        bit              use2;
        bit              we;
        int              rs1;
        int              rs2;
        int              rd;
    } dec_t;

    // architectural state plus the rd of every issued, unretired write
    logic [XLEN-1:0] regs [32];
    int              inflight [$];
    bit              m_valid;
    logic [31:0]     m_instr;
    logic [XLEN-1:0] m_pc;

    function automatic int pending(input int r);
        int c = 0;
        foreach (inflight[i]) if (inflight[i] == r) c++;
        return c;
    endfunction

    function automatic dec_t decode(input logic [31:0] i);
        dec_t d;
        longint v = 0;
        d.rs1 = int'(i[19:15]);
        d.rs2 = int'(i[24:20]);
        d.rd  = int'(i[11:7]);
        d.use1 = 0; d.use2 = 0; d.we = 0; d.imm_ok = 1;
        case (i[6:0])
            7'h37: begin d.kind = K_LUI;   d.we = 1;
                   v = longint'($signed(i[31:12])) * 4096; end
            7'h17: begin d.kind = K_AUIPC; d.we = 1;
                   v = longint'($signed(i[31:12])) * 4096; end
            7'h6f: begin d.kind = K_JAL;   d.we = 1;
                   v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})); end
            7'h67: begin d.kind = K_JALR;  d.we = 1; d.use1 = 1;
                   v = longint'($signed(i[31:20])); end
            7'h63: begin d.kind = K_BR;    d.use1 = 1; d.use2 = 1;
                   v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})); end
            7'h03: begin d.kind = K_LD;    d.we = 1; d.use1 = 1;
                   v = longint'($signed(i[31:20])); end
            7'h23: begin d.kind = K_ST;    d.use1 = 1; d.use2 = 1;
                   v = longint'($signed({i[31:25], i[11:7]})); end
            7'h13: begin d.kind = K_OPI;   d.we = 1; d.use1 = 1;
                   v = longint'($signed(i[31:20])); end
            7'h33: begin d.kind = K_OP;    d.we = 1; d.use1 = 1; d.use2 = 1;
                   d.imm_ok = 0; end
            default: begin d.kind = K_BAD; d.imm_ok = 0; end
        endcase
        d.imm = XLEN'(v);
        d.we  = d.we && (d.rd != 0);
        return d;
    endfunction

    function automatic bit br_cond(input logic [2:0] f3,
                                   input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return !($signed(a) < $signed(b));
            3'd6: return a < b;
            3'd7: return !(a < b);
            default: return 0;
        endcase
    endfunction

    // one clock: drive at negedge, score combinational outputs, advance model at posedge
    task automatic step(input bit r, input bit fv, input logic [31:0] ins,
                        input logic [XLEN-1:0] pcv, input bit ea, input bit wv,
                        input logic [4:0] wrd, input logic [XLEN-1:0] wd);
        dec_t d;
        bit b1, b2, stall, allow, outv, fire, taken;
        logic [XLEN-1:0] v1, v2, tgt;
        int idx;
        @(negedge clk);
        rst = r; fs_to_ds_valid = fv; fs_data = {ins, pcv};
        es_allowin = ea; wb_we = wv; wb_rd = wrd; wb_wdata = wd;
        #1;
        if (r) begin
            check("rst_allowin", ds_allowin, 1);
            check("rst_valid", ds_to_es_valid, 0);
            check("rst_br_taken", br_taken, 0);
            check("rst_br_target", br_target, 0);
            @(posedge clk);
            m_valid = 0;
            inflight.delete();
            foreach (regs[i]) regs[i] = '0;
            return;
        end
        d = decode(m_instr);
        b1 = BYPASS && wv && d.use1 && (int'(wrd) == d.rs1) && pending(d.rs1) == 1;
        b2 = BYPASS && wv && d.use2 && (int'(wrd) == d.rs2) && pending(d.rs2) == 1;
        v1 = b1 ? wd : regs[d.rs1];
        v2 = b2 ? wd : regs[d.rs2];
        stall = m_valid && ((d.use1 && pending(d.rs1) > 0 && !b1) ||
                            (d.use2 && pending(d.rs2) > 0 && !b2) ||
                            (d.we && pending(d.rd) == SB_MAX));
        allow = !m_valid || (!stall && ea);
        outv  = m_valid && !stall;
        fire  = outv && ea;
        taken = fire && (d.kind == K_JAL || d.kind == K_JALR ||
                         (d.kind == K_BR && br_cond(m_instr[14:12], v1, v2)));
        if (d.kind == K_JALR) tgt = (v1 + d.imm) & ~XLEN'(1);
        else                  tgt = m_pc + d.imm;
        check("allowin", ds_allowin, allow);
        check("to_es_valid", ds_to_es_valid, outv);
        check("br_taken", br_taken, taken);
        check("br_target", br_target, taken ? tgt : '0);
        if (m_valid) begin
            check("rf_we", ds_data[0], d.we);
            check("rd", ds_data[5:1], m_instr[11:7]);
            check("pc", ds_data[XLEN+5:6], m_pc);
            if (d.use1) check("rs1_val", ds_data[2*XLEN+5:XLEN+6], v1);
            if (d.use2) check("rs2_val", ds_data[3*XLEN+5:2*XLEN+6], v2);
            if (d.imm_ok) check("imm", ds_data[4*XLEN+5:3*XLEN+6], d.imm);
        end
        @(posedge clk);
        if (wv && wrd != 0) begin
            regs[wrd] = wd;
            idx = -1;
            for (int i = 0; i < inflight.size(); i++)
                if (idx < 0 && inflight[i] == int'(wrd)) idx = i;
            if (idx >= 0) inflight.delete(idx);
        end
        if (fire && d.we) inflight.push_back(d.rd);
        if (allow) begin
            m_valid = fv && !taken;
            if (fv) begin
                m_instr = ins;
                m_pc    = pcv;
            end
        end
    endtask

    task automatic offer(input logic [31:0] ins, input logic [XLEN-1:0] pcv);
        step(0, 1, ins, pcv, 1, 0, 5'd0, '0);
    endtask

    task automatic idle();
        step(0, 0, 32'h0, '0, 1, 0, 5'd0, '0);
    endtask

    task automatic wb(input int r, input logic [XLEN-1:0] v);
        step(0, 0, 32'h0, '0, 1, 1, 5'(r), v);
    endtask

    task automatic drain();
        for (int k = 0; k < 80 && (inflight.size() > 0 || m_valid); k++) begin
            if (inflight.size() > 0) wb(inflight[0], XLEN'({$urandom, $urandom}));
            else idle();
        end
        check("drain_done", (inflight.size() > 0 || m_valid), 0);
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input int rd,
                                          input int rs1, input int imm);
        logic [11:0] i12 = 12'(imm);
        return {i12, 5'(rs1), 3'b000, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1,
                                          input int rs2, input int imm);
        logic [12:0] b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), f3, b[4:1], b[11], 7'h63};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [14];
        logic [31:0] ins;
        ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h13, 7'h33, 7'h33, 7'h0f, 7'h73};
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 13)];
        ins[11:10] = 2'b00;
        ins[19:18] = 2'b00;
        ins[24:23] = 2'b00;
        if (ins[6:0] == 7'h0f || ins[6:0] == 7'h73) ins[19:15] = 5'd0;
        return ins;
    endfunction

    initial begin
        rst = 1; fs_to_ds_valid = 0; fs_data = '0; es_allowin = 1;
        wb_we = 0; wb_rd = '0; wb_wdata = '0;
        m_valid = 0; m_instr = '0; m_pc = '0;
        foreach (regs[i]) regs[i] = '0;

        step(1, 0, 32'h0, '0, 1, 0, 5'd0, '0);
        step(1, 1, enc_i(7'h13, 1, 0, 1), '0, 1, 0, 5'd0, '0);

        // ADDI x1 then dependent ADD, x1 written back three cycles on
        offer(enc_i(7'h13, 1, 0, 5), 'h0);
        offer(enc_add(2, 1, 1), 'h4);
        idle();
        idle();
        wb(1, 'd5);
        idle();
        drain();

        // taken BEQ drops the instruction IF offers alongside the redirect
        offer(enc_b(3'b000, 0, 0, 16), 'h100);
        offer(enc_i(7'h13, 7, 0, 1), 'h104);
        idle();
        drain();

        // JALR x1, x3, 3 with x3 = 0x200
        offer(enc_i(7'h13, 3, 0, 'h200), 'h200);
        idle();
        wb(3, 'h200);
        offer(enc_i(7'h67, 1, 3, 3), 'h300);
        idle();
        drain();

        // EX backpressure for four cycles while IF keeps offering
        offer(enc_i(7'h13, 4, 0, 7), 'h400);
        for (int k = 0; k < 4; k++)
            step(0, 1, enc_i(7'h13, 9, 0, 9), 'h404, 0, 0, 5'd0, '0);
        idle();
        drain();

        // saturate x5, release with one WB, then fire and WB together
        for (int k = 0; k < 4; k++) offer(enc_i(7'h13, 5, 0, k), XLEN'(32'h500 + 4 * k));
        idle();
        wb(5, 'h11);
        idle();
        wb(5, 'h22);
        offer(enc_i(7'h13, 5, 0, 9), 'h520);
        step(0, 0, 32'h0, '0, 1, 1, 5'd5, 'h33);
        offer(enc_i(7'h13, 5, 0, 10), 'h524);
        idle();
        offer(enc_i(7'h13, 5, 0, 11), 'h528);
        idle();
        idle();
        drain();

        // writes to x0 are ignored
        wb(0, 'hdeadbeef);
        offer(enc_add(6, 0, 0), 'h600);
        idle();
        drain();

        for (int n = 0; n < 3000; n++) begin
            bit fv, ea, wv, r;
            logic [4:0] wrd;
            logic [XLEN-1:0] wd;
            fv = ($urandom % 4) != 0;
            ea = ($urandom % 4) != 0;
            r  = (n == 1500);
            wv = 0; wrd = '0; wd = XLEN'({$urandom, $urandom});
            if (inflight.size() > 0 && ($urandom % 3) == 0) begin
                wv = 1;
                wrd = 5'(inflight[0]);
            end else if (($urandom % 20) == 0) begin
                wv = 1;
            end
            step(r, fv, rand_instr(), XLEN'({$urandom, $urandom}) & ~XLEN'(3),
                 ea, wv, wrd, wd);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
